// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit path and, later, the receive side.
//   - UART_DATA_W           : character width (8N1 framing)
//   - DEFAULT_CLKS_PER_BIT  : 16 MHz / 115200 baud
//   - DEFAULT_FIFO_DEPTH    : default buffer depth in bytes
//   - tx_state_t            : serialiser FSM encoding
//   - level_width()         : width of a 0..depth occupancy count
package uart_tx_fifo_pkg;

    localparam int UART_DATA_W          = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 139;
    localparam int DEFAULT_FIFO_DEPTH   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO. Reusable for transmit and receive buffers.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset (flushes pointers)
//   i_push, i_wdata: write request / data; ignored while o_full
//   i_pop          : read request; ignored while o_empty
//   o_rdata        : entry at the head (valid whenever !o_empty)
//   o_full, o_empty: occupancy flags
//   o_count        : entries currently stored
module uart_sync_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int WIDTH = UART_DATA_W,
    parameter int CNT_W = level_width(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];

    // Accept decisions use the flags as registered this cycle, so a push
    // into a full FIFO is refused even when a pop happens alongside it.
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    // Storage needs no reset: pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes pushed from the bus side queue in a
// FIFO and are serialised LSB first onto o_txd, back-to-back with no gap.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset (aborts any frame)
//   i_wdata, i_wr  : byte and push request (dropped if FIFO full)
//   i_clr_ovrflw   : clears sticky overflow (a same-cycle set wins)
//   o_txd          : registered serial line, idles high
//   o_full         : FIFO holds FIFO_DEPTH bytes
//   o_level        : bytes queued, excluding the one on the wire
//   o_tx_busy      : frame in progress or bytes queued
//   o_overflow     : sticky, a push arrived while full
//
// state   | meaning
// IDLE    | line high, waiting for a queued byte
// START   | start bit (low) for CLKS_PER_BIT cycles
// DATA    | 8 data bits, LSB first, CLKS_PER_BIT cycles each
// STOP    | stop bit (high); pops next byte straight into START if queued
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
    parameter int LEVEL_W      = level_width(FIFO_DEPTH)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [UART_DATA_W-1:0] i_wdata,
    input  logic                   i_wr,
    input  logic                   i_clr_ovrflw,
    output logic                   o_txd,
    output logic                   o_full,
    output logic [LEVEL_W-1:0]     o_level,
    output logic                   o_tx_busy,
    output logic                   o_overflow
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t              r_state;
    tx_state_t              w_state_d;
    logic [BAUD_W-1:0]      r_baud;
    logic [BAUD_W-1:0]      w_baud_d;
    logic [2:0]             r_bit;
    logic [2:0]             w_bit_d;
    logic [UART_DATA_W-1:0] r_shift;
    logic [UART_DATA_W-1:0] w_shift_d;
    logic                   r_txd;
    logic                   w_txd_d;
    logic                   r_overflow;

    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [UART_DATA_W-1:0] w_rdata;
    logic [LEVEL_W-1:0]     w_count;
    logic                   w_baud_end;

    uart_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_W),
        .CNT_W (LEVEL_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_wr),
        .i_wdata (i_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_baud_end = (r_baud == BAUD_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_d;
            r_baud  <= w_baud_d;
            r_bit   <= w_bit_d;
            r_shift <= w_shift_d;
            r_txd   <= w_txd_d;
        end
    end

    // w_txd_d is the line level for the state being entered, so the
    // registered o_txd changes on the same edge as the state.
    always_comb begin
        w_state_d = r_state;
        w_baud_d  = r_baud;
        w_bit_d   = r_bit;
        w_shift_d = r_shift;
        w_txd_d   = r_txd;
        w_pop     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_txd_d = 1'b1;
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_shift_d = w_rdata;
                    w_baud_d  = '0;
                    w_txd_d   = 1'b0;
                    w_state_d = ST_START;
                end
            end
            ST_START: begin
                if (w_baud_end) begin
                    w_baud_d  = '0;
                    w_bit_d   = '0;
                    w_txd_d   = r_shift[0];
                    w_state_d = ST_DATA;
                end else begin
                    w_baud_d = r_baud + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (w_baud_end) begin
                    w_baud_d = '0;
                    if (r_bit == 3'd7) begin
                        w_txd_d   = 1'b1;
                        w_state_d = ST_STOP;
                    end else begin
                        w_bit_d   = r_bit + 3'd1;
                        w_shift_d = r_shift >> 1;
                        w_txd_d   = r_shift[1];
                    end
                end else begin
                    w_baud_d = r_baud + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (w_baud_end) begin
                    w_baud_d = '0;
                    if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_shift_d = w_rdata;
                        w_txd_d   = 1'b0;
                        w_state_d = ST_START;
                    end else begin
                        w_txd_d   = 1'b1;
                        w_state_d = ST_IDLE;
                    end
                end else begin
                    w_baud_d = r_baud + BAUD_W'(1);
                end
            end
            default: begin
                w_txd_d   = 1'b1;
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // Setting wins over clearing so a drop is never lost.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overflow <= 1'b0;
        end else if (i_wr && w_full) begin
            r_overflow <= 1'b1;
        end else if (i_clr_ovrflw) begin
            r_overflow <= 1'b0;
        end
    end

    assign o_txd      = r_txd;
    assign o_full     = w_full;
    assign o_level    = w_count;
    assign o_overflow = r_overflow;
    assign o_tx_busy  = (r_state != ST_IDLE) | (w_count != '0);

endmodule
